// File: rtl/round_controller.sv
// Fight round sequencer: countdown, round timer, KO/timeout detection, result hold.
// Optional BEST_OF_THREE_EN adds per-player round-win counters and multi-round play.
module round_controller #(
    parameter int TICK_DIV      = 100_000_000,
    parameter int ROUND_SEC     = 60,
    parameter int COUNTDOWN_SEC = 3,
    parameter int RESULT_SEC    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic [6:0] p1_hp,
    input  logic [6:0] p2_hp,
    output logic [1:0] game_state,
    output logic       fight_en,
    output logic [6:0] timer_sec,
`ifdef BEST_OF_THREE_EN
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
`endif
    output logic [1:0] countdown
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [6:0] ROUND_V = 7'(ROUND_SEC);
    localparam logic [1:0] CD_V = 2'(COUNTDOWN_SEC);
    localparam logic [3:0] RES_LAST = 4'(RESULT_SEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_FIGHT,
        S_P1,
        S_P2,
        S_DRAW
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    res_cnt;
    logic          start_q;
    logic          armed;
    logic          start_rise;
    logic          res_done;
    logic          entering;
    logic [1:0]    gs_nx;
    logic          fe_nx;

    assign tick       = (tick_cnt == TICK_LAST);
    assign res_done   = tick && (res_cnt == RES_LAST);
    assign entering   = (state_nx != state);
    // armed blocks a button that was already high when reset released
    assign start_rise = start_btn && !start_q && armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            game_state <= 2'b11;
            fight_en   <= 1'b0;
        end else begin
            state      <= state_nx;
            game_state <= gs_nx;
            fight_en   <= fe_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start_rise) state_nx = S_COUNT;
            end
            S_COUNT: begin
                if (tick && countdown == 2'd1) state_nx = S_FIGHT;
            end
            S_FIGHT: begin
                if (p1_hp == 7'd0 && p2_hp == 7'd0) state_nx = S_DRAW;
                else if (p2_hp == 7'd0) state_nx = S_P1;
                else if (p1_hp == 7'd0) state_nx = S_P2;
                else if (tick && timer_sec == 7'd1) begin
                    if (p1_hp > p2_hp) state_nx = S_P1;
                    else if (p2_hp > p1_hp) state_nx = S_P2;
                    else state_nx = S_DRAW;
                end
            end
            S_P1, S_P2, S_DRAW: begin
`ifdef BEST_OF_THREE_EN
                if (res_done) begin
                    if (p1_wins == 2'd2 || p2_wins == 2'd2) state_nx = S_IDLE;
                    else state_nx = S_COUNT;
                end
`else
                if (res_done) state_nx = S_IDLE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        gs_nx = 2'b11;
        fe_nx = 1'b0;
        unique case (state_nx)
            S_FIGHT: begin
                gs_nx = 2'b00;
                fe_nx = 1'b1;
            end
            S_P1:    gs_nx = 2'b01;
            S_P2:    gs_nx = 2'b10;
            default: gs_nx = 2'b11;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            res_cnt   <= '0;
            start_q   <= 1'b0;
            armed     <= 1'b0;
            timer_sec <= ROUND_V;
            countdown <= 2'd0;
        end else begin
            start_q <= start_btn;
            armed   <= armed | ~start_btn;

            if (state == S_IDLE || entering) tick_cnt <= '0;
            else if (tick) tick_cnt <= '0;
            else tick_cnt <= tick_cnt + 1'b1;

            if (entering && state_nx == S_COUNT) begin
                countdown <= CD_V;
                timer_sec <= ROUND_V;
            end else begin
                if (state == S_COUNT && tick && countdown != 2'd0)
                    countdown <= countdown - 2'd1;
                if (state == S_FIGHT && tick && timer_sec != 7'd0)
                    timer_sec <= timer_sec - 7'd1;
            end

            if (entering) res_cnt <= '0;
            else if (tick) res_cnt <= res_cnt + 4'd1;
        end
    end

`ifdef BEST_OF_THREE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_wins <= 2'd0;
            p2_wins <= 2'd0;
        end else if (state == S_IDLE && state_nx == S_COUNT) begin
            p1_wins <= 2'd0;
            p2_wins <= 2'd0;
        end else if (state == S_FIGHT && state_nx == S_P1) begin
            p1_wins <= p1_wins + 2'd1;
        end else if (state == S_FIGHT && state_nx == S_P2) begin
            p2_wins <= p2_wins + 2'd1;
        end
    end
`endif

endmodule
